data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 128×16 data memory. It lets the CPU load/store unit (port 0) and the debug/DMA loader (port 1) share the memory's one address/data/control port. Access order is round-robin with a request/grant handshake. Every access goes through a one-entry issue stage that drives the memory's MemRead/MemWrite, AdresaNeHyrje and WriteData pins. Read data is registered on the way back.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/data_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data memory, its arbiter and the CPU datapath.
package data_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 128;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2,
        OP_ERR  = 2'd3
    } op_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Out-of-range addresses become OP_ERR whatever the direction.
    function automatic op_t decodeOp(input logic valid, input logic we, input logic inRange);
        if (!valid)
            return OP_NONE;
        else if (!inRange)
            return OP_ERR;
        else if (we)
            return OP_WR;
        else
            return OP_RD;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the port not granted last wins.
module rr_arb2
    import data_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic lastGnt;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | (lastGnt == PORT_DBG));
        gnt[1] = req[1] & (~req[0] | (lastGnt == PORT_CPU));
    end

    // Pointer only moves on a grant, so idle cycles preserve fairness history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lastGnt <= PORT_DBG;
        else if (gnt[0])
            lastGnt <= PORT_CPU;
        else if (gnt[1])
            lastGnt <= PORT_DBG;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of the single-port data memory between the CPU and debug/DMA ports,
// with a one-entry issue stage and registered per-port responses.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = data_mem_pkg::ADDR_W,
    parameter int DATA_W = data_mem_pkg::DATA_W,
    parameter int DEPTH  = data_mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        reqVec;
    logic [1:0]        gntVec;
    logic              selPort;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    op_t               selOp;

    op_t               opQ;
    logic              portQ;
    logic              memReadQ;
    logic              memWriteQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;

    assign reqVec = {req1, req0};

    rr_arb2 uArb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (reqVec),
        .gnt   (gntVec)
    );

    assign gnt0 = gntVec[0];
    assign gnt1 = gntVec[1];

    always_comb begin
        selPort  = gntVec[1];
        selWe    = selPort ? we1    : we0;
        selAddr  = selPort ? addr1  : addr0;
        selWdata = selPort ? wdata1 : wdata0;
        selOp    = decodeOp(|gntVec, selWe, selAddr < ADDR_W'(DEPTH));
    end

    // Memory pins are registered directly so nothing combinational reaches the memory;
    // the async reset clears mem_write, dropping any write still in its drive cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ       <= OP_NONE;
            portQ     <= PORT_CPU;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            opQ       <= selOp;
            portQ     <= selPort;
            memReadQ  <= (selOp == OP_RD);
            memWriteQ <= (selOp == OP_WR);
            memAddrQ  <= (selOp == OP_RD || selOp == OP_WR) ? selAddr : '0;
            memWdataQ <= (selOp == OP_WR) ? selWdata : '0;
        end
    end

    assign mem_read  = memReadQ;
    assign mem_write = memWriteQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;

    for (genvar gi = 0; gi < 2; gi++) begin : gRsp
        logic              hit;
        logic              rvalidR;
        logic              errR;
        logic [DATA_W-1:0] rdataR;

        assign hit = (opQ != OP_NONE) && (portQ == 1'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalidR <= 1'b0;
                errR    <= 1'b0;
                rdataR  <= '0;
            end else begin
                rvalidR <= hit;
                errR    <= hit && (opQ == OP_ERR);
                rdataR  <= (hit && opQ == OP_RD) ? mem_rdata : '0;
            end
        end
    end

    assign rvalid0 = gRsp[0].rvalidR;
    assign rvalid1 = gRsp[1].rvalidR;
    assign err0    = gRsp[0].errR;
    assign err1    = gRsp[1].errR;
    assign rdata0  = gRsp[0].rdataR;
    assign rdata1  = gRsp[1].rdataR;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: memory model, grant/response scoreboard, vector table and corner sequences.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_write, mem_read;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] initVal(input int i);
        return 16'(i) * 16'd7 + 16'h0100;
    endfunction

    // Memory model: combinational read, write on rising edge.
    logic [15:0] tbMem [0:127];
    logic        memLoaded = 1'b0;
    assign mem_rdata = (mem_addr < 16'd128) ? tbMem[mem_addr[6:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 128; i++) tbMem[i] <= initVal(i);
            memLoaded <= 1'b1;
        end else if (mem_write && mem_addr < 16'd128) begin
            tbMem[mem_addr[6:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        port;
        logic [15:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } memx_t;

    exp_t        sbq[$];
    memx_t       memExp = '0;
    logic [15:0] shadow [0:127];
    logic        shLoaded = 1'b0;
    logic        tbLast = 1'b1;
    int          cyc = 0;
    logic [15:0] lastRd [2];
    logic        lastErr [2];

    // Monitor: independent arbitration/memory model, checked away from the clock edge.
    always @(negedge clk) begin
        logic eg0, eg1, p, we;
        logic [15:0] a, d;
        exp_t e;
        if (!shLoaded) begin
            for (int i = 0; i < 128; i++) shadow[i] = initVal(i);
            shLoaded = 1'b1;
        end
        cyc++;
        if (!rst_n) begin
            sbq.delete();
            memExp = '0;
            tbLast = 1'b1;
            chk("rst_outs", 32'(|{gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write,
                                  mem_addr, mem_wdata, rdata0, rdata1}), 32'd0);
        end else begin
            chk("mem_read", 32'(mem_read), 32'(memExp.rd));
            chk("mem_write", 32'(mem_write), 32'(memExp.wr));
            chk("mem_addr", 32'(mem_addr), 32'(memExp.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(memExp.wdata));
            if (memExp.wr) shadow[memExp.addr[6:0]] = memExp.wdata;

            eg0 = req0 && (!req1 || tbLast);
            eg1 = req1 && (!req0 || !tbLast);
            chk("gnt", 32'({gnt1, gnt0}), 32'({eg1, eg0}));
            memExp = '0;
            if (eg0 || eg1) begin
                p  = eg1;
                we = p ? we1 : we0;
                a  = p ? addr1 : addr0;
                d  = p ? wdata1 : wdata0;
                tbLast = p;
                e.port = p;
                e.due  = cyc + 2;
                e.err  = 1'b0;
                e.rdata = 16'h0000;
                if (a >= 16'd128) begin
                    e.err = 1'b1;
                end else if (we) begin
                    memExp.wr = 1'b1; memExp.addr = a; memExp.wdata = d;
                end else begin
                    memExp.rd = 1'b1; memExp.addr = a;
                    e.rdata = shadow[a[6:0]];
                end
                sbq.push_back(e);
            end

            chk("err_no_rvalid", 32'((err0 && !rvalid0) || (err1 && !rvalid1)), 32'd0);
            if (rvalid0 || rvalid1) begin
                chk("rvalid_both", 32'(rvalid0 && rvalid1), 32'd0);
                if (sbq.size() == 0) begin
                    chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_port", 32'(rvalid1), 32'(e.port));
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                    chk("rsp_rdata", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.rdata));
                    chk("rsp_err", 32'(rvalid1 ? err1 : err0), 32'(e.err));
                    lastRd[rvalid1]  = rvalid1 ? rdata1 : rdata0;
                    lastErr[rvalid1] = rvalid1 ? err1 : err0;
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("rvalid_missing", 32'(sbq[0].due), 32'(-1));
                void'(sbq.pop_front());
            end
        end
    end

    // Present one request, hold it until granted, drop it just after the granting edge.
    task automatic issue(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d);
        logic granted = 1'b0;
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            granted = p ? gnt1 : gnt0;
        end
        chk("gnt_timeout", 32'(granted), 32'd1);
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic r0, w0; logic [15:0] a0;
        logic r1, w1; logic [15:0] a1;
        logic [1:0] eg;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b01};
        vt[1]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b10};
        vt[2]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b01};
        vt[3]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b10};
        vt[4]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b01};
        vt[5]  = '{1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 2'b10};
        vt[6]  = '{1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 16'd4, 2'b10};
        vt[7]  = '{1'b1, 1'b0, 16'd6, 1'b1, 1'b0, 16'd4, 2'b01};
        vt[8]  = '{1'b1, 1'b0, 16'd8, 1'b0, 1'b0, 16'd4, 2'b01};
        vt[9]  = '{1'b1, 1'b0, 16'd8, 1'b1, 1'b0, 16'd9, 2'b10};
        vt[10] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 2'b00};

        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Tie sequence straight after reset: port 0 must win first.
        for (int i = 0; i < 11; i++) begin
            req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0;
            req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), 32'({gnt1, gnt0}), 32'(vt[i].eg));
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(4);

        // Write then cross-port read of the same word.
        issue(1'b0, 1'b1, 16'd5, 16'hBEEF);
        chk("wr5_mem_write", 32'(mem_write), 32'd1);
        chk("wr5_mem_addr", 32'(mem_addr), 32'd5);
        chk("wr5_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        idle(1);
        chk("wr5_rvalid0", 32'(rvalid0), 32'd1);
        issue(1'b1, 1'b0, 16'd5, 16'h0000);
        idle(4);
        chk("rd5_port1", 32'(lastRd[1]), 32'hBEEF);

        // Back-to-back write/read of the same address from port 0.
        issue(1'b0, 1'b1, 16'd10, 16'h1234);
        issue(1'b0, 1'b0, 16'd10, 16'h0000);
        idle(4);
        chk("rd10_port0", 32'(lastRd[0]), 32'h1234);

        // Out-of-range read, followed immediately by a normal port 0 read.
        issue(1'b1, 1'b0, 16'd200, 16'h0000);
        chk("err_no_mem_read", 32'(mem_read), 32'd0);
        issue(1'b0, 1'b0, 16'd5, 16'h0000);
        idle(4);
        chk("err1_seen", 32'(lastErr[1]), 32'd1);
        chk("rd5_after_err", 32'(lastRd[0]), 32'hBEEF);

        // Reset landing in the drive cycle of a write must drop it.
        issue(1'b0, 1'b1, 16'd3, 16'h0007);
        idle(3);
        issue(1'b0, 1'b1, 16'd3, 16'hDEAD);
        #1 rst_n = 1'b0;
        #1 chk("rst_drops_write", 32'(mem_write), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        issue(1'b1, 1'b0, 16'd3, 16'h0000);
        idle(4);
        chk("rd3_after_rst", 32'(lastRd[1]), 32'h0007);

        // Idle period: outputs quiet, pointer kept (last grant was port 1).
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'(|{gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write,
                                  mem_addr, mem_wdata, rdata0, rdata1}), 32'd0);
            @(posedge clk); #1;
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd12;
        @(negedge clk);
        chk("idle_tie_gnt", 32'({gnt1, gnt0}), 32'b01);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        idle(5);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

endmodule
